// File: rtl/pixel_histogram_if.sv
// ---------------------------------------------------------------------------
// pixel_histogram_if
//   Bundles the pixel-stream inputs and the bin-readout handshake of the
//   pixel_histogram block. clk and rst_n stay plain module ports.
//
//   Pixel side (into the histogram):
//     pix_in[7:0], pix_valid, frame_start, frame_end
//   Readout side:
//     out_valid, out_ready, out_bin[BIN_BITS-1:0], out_count[CNT_W-1:0],
//     out_last, plus status busy and total_pix[CNT_W-1:0]
//
//   master : the environment (pixel operator + readout consumer)
//   slave  : the histogram block
// ---------------------------------------------------------------------------
interface pixel_histogram_if #(
    parameter int BIN_BITS = 8,
    parameter int CNT_W    = 20
);
    logic [7:0]          pix_in;
    logic                pix_valid;
    logic                frame_start;
    logic                frame_end;
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic [BIN_BITS-1:0] out_bin;
    logic [CNT_W-1:0]    out_count;
    logic                out_last;
    logic [CNT_W-1:0]    total_pix;

    modport master (
        output pix_in, pix_valid, frame_start, frame_end, out_ready,
        input  busy, out_valid, out_bin, out_count, out_last, total_pix
    );

    modport slave (
        input  pix_in, pix_valid, frame_start, frame_end, out_ready,
        output busy, out_valid, out_bin, out_count, out_last, total_pix
    );
endinterface

// File: rtl/pixel_histogram.sv
// ---------------------------------------------------------------------------
// pixel_histogram
//   Builds a per-frame intensity histogram of an 8-bit pixel stream, then
//   streams every bin out over valid/ready, zeroing each bin as it is taken,
//   and re-arms for the next frame.
//
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset (restarts the clearing pass)
//     bus    : pixel_histogram_if.slave
//              pix_in/pix_valid     pixel stream
//              frame_start/end      one-cycle framing pulses
//              busy                 high while clearing, draining, reading out
//              out_valid/out_ready  bin record handshake
//              out_bin/out_count    record contents, out_last on final bin
//              total_pix            saturating pixel count of last frame
//
//   Bin memory is a simple dual-port array (one write, one registered read)
//   with no reset; the CLEAR pass zeroes it after every reset.
// ---------------------------------------------------------------------------
module pixel_histogram #(
    parameter int BIN_BITS = 8,
    parameter int CNT_W    = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    pixel_histogram_if.slave bus
);
    localparam int                  NBINS    = 1 << BIN_BITS;
    localparam logic [BIN_BITS-1:0] LAST_BIN = BIN_BITS'(NBINS - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_READOUT
    } state_t;

    state_t state_q, state_d;

    // Bin storage
    logic [CNT_W-1:0]    mem [NBINS];
    logic [CNT_W-1:0]    rd_data_q;
    logic                rd_en;
    logic [BIN_BITS-1:0] rd_addr;
    logic                wr_en;
    logic [BIN_BITS-1:0] wr_addr;
    logic [CNT_W-1:0]    wr_data;

    // Control / pipeline registers
    logic [BIN_BITS-1:0] clr_q;
    logic                drain_q;
    logic                s1_valid_q;
    logic [BIN_BITS-1:0] s1_addr_q;
    logic                wb_valid_q;
    logic [BIN_BITS-1:0] wb_addr_q;
    logic [CNT_W-1:0]    wb_data_q;
    logic [CNT_W-1:0]    run_q;
    logic [CNT_W-1:0]    total_q;
    logic [BIN_BITS-1:0] rd_ptr_q;
    logic                out_valid_q;
    logic [BIN_BITS-1:0] out_bin_q;
    logic [CNT_W-1:0]    out_count_q;

    // Combinational helpers
    logic [BIN_BITS-1:0] pix_bin;
    logic                accept;
    logic                handshake;
    logic                load;
    logic [CNT_W-1:0]    s1_cur;
    logic [CNT_W-1:0]    s1_inc;

    assign pix_bin = bus.pix_in[7 -: BIN_BITS];

    // Memory: one write port, one registered read port, no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    // Next-state, memory port steering and pipeline control.
    always_comb begin
        state_d   = state_q;
        rd_en     = 1'b0;
        rd_addr   = pix_bin;
        wr_en     = 1'b0;
        wr_addr   = s1_addr_q;
        wr_data   = '0;
        accept    = 1'b0;
        load      = 1'b0;
        handshake = out_valid_q && bus.out_ready;

        // The read for this pixel was issued on the same edge that wrote the
        // previous pixel's result, so it may be stale by exactly that one
        // write; the write-back register supplies the fresh value instead.
        s1_cur = (wb_valid_q && (wb_addr_q == s1_addr_q)) ? wb_data_q : rd_data_q;
        s1_inc = (s1_cur == CNT_MAX) ? s1_cur : s1_cur + CNT_W'(1);

        if (s1_valid_q) begin
            wr_en   = 1'b1;
            wr_addr = s1_addr_q;
            wr_data = s1_inc;
        end

        case (state_q)
            S_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_q;
                wr_data = '0;
                if (clr_q == LAST_BIN) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.frame_start) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus.pix_valid) begin
                    accept  = 1'b1;
                    rd_en   = 1'b1;
                    rd_addr = pix_bin;
                end
                if (bus.frame_end) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // First DRAIN cycle retires the last increment; the second
                // prefetches bin 0 for the readout.
                if (drain_q) begin
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    state_d = S_READOUT;
                end
            end
            S_READOUT: begin
                if (handshake) begin
                    wr_en   = 1'b1;
                    wr_addr = out_bin_q;
                    wr_data = '0;
                end
                if (handshake && (out_bin_q == LAST_BIN)) begin
                    state_d = S_IDLE;
                end else if (!out_valid_q || handshake) begin
                    // Move the prefetched bin into the output register and
                    // prefetch the one after it.
                    load    = 1'b1;
                    rd_en   = 1'b1;
                    rd_addr = rd_ptr_q;
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_CLEAR;
            clr_q       <= '0;
            drain_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            run_q       <= '0;
            total_q     <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_count_q <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= (state_q == S_CLEAR) ? clr_q + BIN_BITS'(1) : '0;
            drain_q <= (state_q == S_DRAIN);

            s1_valid_q <= accept;
            if (accept) begin
                s1_addr_q <= pix_bin;
            end

            wb_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                wb_addr_q <= s1_addr_q;
                wb_data_q <= s1_inc;
            end

            if ((state_q == S_IDLE) && bus.frame_start) begin
                run_q <= '0;
            end else if (accept && (run_q != CNT_MAX)) begin
                run_q <= run_q + CNT_W'(1);
            end

            if ((state_q == S_DRAIN) && drain_q) begin
                total_q <= run_q;
            end

            // Bin 0 is prefetched while leaving DRAIN, so the pointer starts
            // at the bin after it.
            if (state_q == S_DRAIN) begin
                rd_ptr_q <= BIN_BITS'(1);
            end else if (load) begin
                rd_ptr_q <= rd_ptr_q + BIN_BITS'(1);
            end

            if (load) begin
                out_valid_q <= 1'b1;
                out_bin_q   <= rd_ptr_q - BIN_BITS'(1);
                out_count_q <= rd_data_q;
            end else if (handshake) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.busy      = (state_q == S_CLEAR) || (state_q == S_DRAIN) || (state_q == S_READOUT);
    assign bus.out_valid = out_valid_q;
    assign bus.out_bin   = out_bin_q;
    assign bus.out_count = out_count_q;
    assign bus.out_last  = out_valid_q && (out_bin_q == LAST_BIN);
    assign bus.total_pix = total_q;

endmodule

// File: tb/tb_pixel_histogram.sv
// ---------------------------------------------------------------------------
// tb_pixel_histogram
//   Three histogram instances share one pixel stream and one out_ready:
//     u_a : BIN_BITS=8, CNT_W=20  (default configuration)
//     u_b : BIN_BITS=2, CNT_W=20  (coarse bins)
//     u_c : BIN_BITS=8, CNT_W=4   (early saturation)
//   Expected bins are computed by counting the frame's accepted pixels per
//   bin and clamping to the counter maximum.
// ---------------------------------------------------------------------------
module tb_pixel_histogram;
    localparam int MAX20 = (1 << 20) - 1;
    localparam int MAX4  = (1 << 4) - 1;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b1;
    logic [7:0] pix_in      = '0;
    logic       pix_valid   = 1'b0;
    logic       frame_start = 1'b0;
    logic       frame_end   = 1'b0;
    logic       out_ready   = 1'b0;

    int ready_mode = 0;
    int n_cmp = 0;
    int n_mis = 0;
    int nb_a = 0;
    int nb_b = 0;
    int nb_c = 0;

    logic [7:0] stim_q[$];
    logic [7:0] frame_px[$];
    int exp_a[256];
    int exp_b[4];
    int exp_c[256];
    int tot_a, tot_b, tot_c;

    always #5 clk = ~clk;

    pixel_histogram_if #(.BIN_BITS(8), .CNT_W(20)) if_a ();
    pixel_histogram_if #(.BIN_BITS(2), .CNT_W(20)) if_b ();
    pixel_histogram_if #(.BIN_BITS(8), .CNT_W(4))  if_c ();

    assign if_a.pix_in = pix_in;  assign if_a.pix_valid = pix_valid;
    assign if_a.frame_start = frame_start; assign if_a.frame_end = frame_end;
    assign if_a.out_ready = out_ready;
    assign if_b.pix_in = pix_in;  assign if_b.pix_valid = pix_valid;
    assign if_b.frame_start = frame_start; assign if_b.frame_end = frame_end;
    assign if_b.out_ready = out_ready;
    assign if_c.pix_in = pix_in;  assign if_c.pix_valid = pix_valid;
    assign if_c.frame_start = frame_start; assign if_c.frame_end = frame_end;
    assign if_c.out_ready = out_ready;

    pixel_histogram #(.BIN_BITS(8), .CNT_W(20)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    pixel_histogram #(.BIN_BITS(2), .CNT_W(20)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    pixel_histogram #(.BIN_BITS(8), .CNT_W(4))  u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic void build_model();
        foreach (exp_a[i]) exp_a[i] = 0;
        foreach (exp_b[i]) exp_b[i] = 0;
        foreach (exp_c[i]) exp_c[i] = 0;
        foreach (frame_px[i]) begin
            exp_a[int'(frame_px[i])]++;
            exp_b[int'(frame_px[i]) / 64]++;
            exp_c[int'(frame_px[i])]++;
        end
        foreach (exp_a[i]) if (exp_a[i] > MAX20) exp_a[i] = MAX20;
        foreach (exp_b[i]) if (exp_b[i] > MAX20) exp_b[i] = MAX20;
        foreach (exp_c[i]) if (exp_c[i] > MAX4)  exp_c[i] = MAX4;
        tot_a = (frame_px.size() > MAX20) ? MAX20 : frame_px.size();
        tot_b = tot_a;
        tot_c = (frame_px.size() > MAX4) ? MAX4 : frame_px.size();
    endfunction

    // out_ready pattern: 0 = always ready, 1 = 1,0,0,1 repeating, else random
    initial begin
        int r = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((r % 4) == 0) || ((r % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            r++;
        end
    end

    // Record monitors: every presented record must be the next expected bin,
    // including while stalled; records beyond the last bin are errors.
    always @(negedge clk) begin
        if (rst_n && if_a.out_valid) begin
            if (nb_a < 256) begin
                check("a_bin", if_a.out_bin, nb_a);
                check("a_count", if_a.out_count, exp_a[nb_a]);
                check("a_last", if_a.out_last, (nb_a == 255));
                if (out_ready) nb_a++;
            end else begin
                check("a_extra_record", if_a.out_valid, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && if_b.out_valid) begin
            if (nb_b < 4) begin
                check("b_bin", if_b.out_bin, nb_b);
                check("b_count", if_b.out_count, exp_b[nb_b]);
                check("b_last", if_b.out_last, (nb_b == 3));
                if (out_ready) nb_b++;
            end else begin
                check("b_extra_record", if_b.out_valid, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && if_c.out_valid) begin
            if (nb_c < 256) begin
                check("c_bin", if_c.out_bin, nb_c);
                check("c_count", if_c.out_count, exp_c[nb_c]);
                check("c_last", if_c.out_last, (nb_c == 255));
                if (out_ready) nb_c++;
            end else begin
                check("c_extra_record", if_c.out_valid, 0);
            end
        end
    end

    task automatic apply_reset();
        int ca, cb, cc;
        rst_n = 1'b0;
        #1;
        check("rst_a_busy", if_a.busy, 1);
        check("rst_a_valid", if_a.out_valid, 0);
        check("rst_a_bin", if_a.out_bin, 0);
        check("rst_a_count", if_a.out_count, 0);
        check("rst_a_last", if_a.out_last, 0);
        check("rst_a_total", if_a.total_pix, 0);
        check("rst_b_valid", if_b.out_valid, 0);
        check("rst_c_valid", if_c.out_valid, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nb_a = 0; nb_b = 0; nb_c = 0;
        ca = -1; cb = -1; cc = -1;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk);
            #1;
            if (ca < 0 && !if_a.busy) ca = k;
            if (cb < 0 && !if_b.busy) cb = k;
            if (cc < 0 && !if_c.busy) cc = k;
            if (ca >= 0 && cb >= 0 && cc >= 0) break;
        end
        check("a_clear_cycles", ca, 256);
        check("b_clear_cycles", cb, 4);
        check("c_clear_cycles", cc, 256);
    endtask

    // Sends stim_q as one frame; with end_pix the last pixel rides on
    // frame_end. stop_at >= 0 returns once that many A-records were taken.
    task automatic run_frame(input int gap_max, input bit end_pix, input int mode,
                             input bit poke_start, input int stop_at);
        int n, ncol, la, lb, lc;
        ready_mode = mode;
        repeat (3) begin
            @(posedge clk);
            #1;
            pix_valid = 1'b1;
            pix_in    = 8'($urandom);
        end
        pix_valid = 1'b0;
        frame_px.delete();
        nb_a = 0; nb_b = 0; nb_c = 0;
        @(posedge clk); #1; frame_start = 1'b1;
        @(posedge clk); #1; frame_start = 1'b0;
        n    = stim_q.size();
        ncol = (end_pix && n > 0) ? n - 1 : n;
        for (int i = 0; i < ncol; i++) begin
            pix_valid   = 1'b1;
            pix_in      = stim_q[i];
            frame_start = poke_start && (i == 1);
            frame_px.push_back(stim_q[i]);
            @(posedge clk); #1;
            pix_valid   = 1'b0;
            frame_start = 1'b0;
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk); #1;
                end
            end
        end
        frame_end = 1'b1;
        if (end_pix && n > 0) begin
            pix_valid = 1'b1;
            pix_in    = stim_q[n-1];
            frame_px.push_back(stim_q[n-1]);
        end
        build_model();
        @(posedge clk); #1;
        frame_end = 1'b0;
        pix_valid = 1'b0;
        la = -1; lb = -1; lc = -1;
        for (int k = 0; k <= 8; k++) begin
            if (la < 0 && if_a.out_valid) la = k;
            if (lb < 0 && if_b.out_valid) lb = k;
            if (lc < 0 && if_c.out_valid) lc = k;
            @(posedge clk); #1;
        end
        $display("frame: %0d pixels, first out_valid after %0d/%0d/%0d cycles", n, la, lb, lc);
        check("a_valid_within_4", (la >= 0 && la <= 4), 1);
        check("b_valid_within_4", (lb >= 0 && lb <= 4), 1);
        check("c_valid_within_4", (lc >= 0 && lc <= 4), 1);
        for (int k = 0; k < 4000; k++) begin
            if (stop_at >= 0) begin
                if (nb_a >= stop_at) break;
            end else if (nb_a >= 256 && nb_b >= 4 && nb_c >= 256) begin
                break;
            end
            @(posedge clk);
            #2;
            pix_valid = 1'($urandom_range(0, 1));
            pix_in    = 8'($urandom);
        end
        pix_valid = 1'b0;
        if (stop_at >= 0) begin
            check("a_reached_stop_bin", nb_a, stop_at);
            return;
        end
        check("a_records", nb_a, 256);
        check("b_records", nb_b, 4);
        check("c_records", nb_c, 256);
        check("a_total", if_a.total_pix, tot_a);
        check("b_total", if_b.total_pix, tot_b);
        check("c_total", if_c.total_pix, tot_c);
        check("a_valid_after", if_a.out_valid, 0);
        check("a_busy_after", if_a.busy, 0);
        check("b_busy_after", if_b.busy, 0);
        check("c_busy_after", if_c.busy, 0);
    endtask

    task automatic fill_random();
        int len;
        logic [7:0] hot[4];
        len = $urandom_range(1, 300);
        foreach (hot[i]) hot[i] = 8'($urandom);
        stim_q.delete();
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 1) == 1) stim_q.push_back(hot[$urandom_range(0, 3)]);
            else                           stim_q.push_back(8'($urandom));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        apply_reset();

        // Empty frame
        stim_q.delete();
        run_frame(0, 1'b0, 0, 1'b0, -1);

        // Back-to-back same-bin pixels, last pixel on frame_end
        stim_q = '{8'h10, 8'h10, 8'h10, 8'hFF, 8'h00, 8'h10};
        run_frame(0, 1'b1, 0, 1'b0, -1);
        // Same frame again with a stalling consumer
        run_frame(0, 1'b1, 1, 1'b0, -1);

        // Coarse-bin boundaries
        stim_q = '{8'h00, 8'h3F, 8'h40, 8'hC0, 8'hFF};
        run_frame(0, 1'b0, 2, 1'b0, -1);

        // Saturation of the narrow counters
        stim_q.delete();
        repeat (20) stim_q.push_back(8'h80);
        run_frame(0, 1'b0, 0, 1'b0, -1);

        // Random frames with gaps, stray frame_start and random ready
        repeat (3) begin
            fill_random();
            run_frame(2, 1'($urandom_range(0, 1)), 2, 1'b1, -1);
        end

        // Reset in the middle of readout, then a one-pixel frame
        fill_random();
        run_frame(0, 1'b0, 0, 1'b0, 37);
        apply_reset();
        stim_q = '{8'h25};
        run_frame(0, 1'b0, 0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
